mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the five-stage RISC-V core. It sits between the EX/MEM and MEM/WB latches and executes the load/store requests issued by `ex` (`aluop`, `mem_addr`, store data carried on `wdata`) over the core's byte-wide RAM port. Loads are sign- or zero-extended; all other instructions pass through. The block holds the pipeline with `stall_req_o` until the access finishes.

## Interface
- No parameters. Bus widths come from the shared defines header.
- Byte addresses are 32 bits, register addresses are 5 bits, `aluop_i` is 8 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wd_i` in 5: destination register from EX/MEM.
- `wreg_i` in 1: write-enable from EX/MEM.
- `wdata_i` in 32: ALU result, or store data for stores.
- `aluop_i` in 8: EX_* code. Only EX_LB/LH/LW/LBU/LHU/SB/SH/SW trigger an access. Any other code is "non-memory".
- `mem_addr_i` in 32: effective byte address.
- `mem_gnt_i` in 1: RAM port granted to this stage this cycle (arbiter shared with IF).
- `mem_din_i` in 8: RAM read data, valid one cycle after the address was issued.
- `wd_o` out 5, `wreg_o` out 1, `wdata_o` out 32: to MEM/WB and forwarding.
- `stall_req_o` out 1: hold IF..EX/MEM this cycle.
- `mem_a_o` out 32: RAM byte address.
- `mem_dout_o` out 8: RAM write data.
- `mem_wr_o` out 1: 1 = write, 0 = read.

## Operation
- **Size n:** LB/LBU/SB = 1; LH/LHU/SH = 2; LW/SW = 4.
- **Byte order:** byte k is at address `mem_addr_i+k`, computed modulo 2^32 (wraps from 0xFFFFFFFF to 0). Little-endian.
- **Alignment:** no alignment check is made.
- **States:** IDLE, XFER, FIN.
- **Registered state:**
  - `iss`: issue counter, 0..4.
  - `pend`: byte issued last cycle.
  - `buf`: 32-bit capture register.
- **IDLE:**
  - Non-memory op: combinational pass-through. `wd_o`/`wreg_o`/`wdata_o` = inputs, `stall_req_o`=0, stay in IDLE.
  - Memory op: `stall_req_o`=1 and `wreg_o`=0. Clear `iss`, `pend` and `buf`, then go to XFER.
- **XFER:**
  - `stall_req_o`=1 and `wreg_o`=0.
  - **Issue:** happens when `iss`<n and `mem_gnt_i`=1.
    - Drive `mem_a_o`=`mem_addr_i+iss`.
    - Store: `mem_wr_o`=1, `mem_dout_o`=`wdata_i[8*iss+7:8*iss]`.
    - Load: `mem_wr_o`=0.
    - Then `iss`++ and set `pend`=1 for loads.
  - Otherwise `mem_wr_o`=0 and `pend`←0.
  - **Capture (loads):** when `pend`=1, `buf[8*(iss-1)+7 -: 8]` ← `mem_din_i`. This is independent of grant.
  - **Exit:**
    - Store: go to FIN on the cycle byte n-1 is issued.
    - Load: go to FIN on the cycle byte n-1 is captured.
- **FIN:**
  - `stall_req_o`=0, `wd_o`=`wd_i`, `wreg_o`=`wreg_i`.
  - `wdata_o` is the extended `buf`: LB sign-extends bit 7, LBU zero-extends, LH sign-extends bit 15, LHU zero-extends, LW passes through.
  - For stores, `wdata_o`=0.
  - The pipeline advances at this edge; next state is IDLE.
  - FIN guarantees the same EX/MEM entry is never executed twice.
- **Idle RAM outputs:** when not issuing, `mem_a_o`=0, `mem_dout_o`=0, `mem_wr_o`=0.

## Timing
- **Reset:** while `rst`=1, all outputs are 0 and state/`iss`/`pend`/`buf` are cleared asynchronously.
- **Reset mid-access:** aborts the access. Bytes already written stay written; no partial writeback occurs.
- **Cycles in the stage with continuous grant** (IDLE + XFER + FIN):
  - SB = 3, SH = 4, SW = 6.
  - LB = 4, LH = 5, LW = 7.
  - Non-memory = 1, with zero stall.
- **Grant low:** each cycle of `mem_gnt_i`=0 during XFER adds one cycle. No address is presented, and a previously pending byte is still captured.
- **Input stability:** EX/MEM inputs are required stable whenever `stall_req_o`=1. The block does not latch them.
- **Back-to-back:** a memory op directly behind another enters IDLE the cycle after FIN. There is no gap cycle beyond IDLE.

## Test plan
- **Pass-through:** reset; aluop=EX_ADD, wd=5, wreg=1, wdata=0x1234 -> same cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o=0, mem_wr_o=0.
- **SW:** SW addr=0x100, wdata=0xA1B2C3D4, grant=1 -> writes D4@0x100, C3@0x101, B2@0x102, A1@0x103 on consecutive cycles. stall_req_o high for 5 cycles, FIN on cycle 6.
- **LB/LBU:** RAM byte 0x80 at 0x20. LB -> wdata_o=0xFFFFFF80; LBU -> 0x00000080. 4 cycles each.
- **LH with grant gaps:** RAM 0x34@0x40, 0x12@0x41. LH with grant low for 2 cycles after the first issue -> wdata_o=0x00001234 in FIN, 7 cycles total, address 0x41 issued only after grant returns.
- **Address wrap:** LW at 0xFFFFFFFE -> byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Result assembled little-endian.
- **Reset mid-SW:** assert rst after 2 bytes are written -> all outputs 0 immediately, state IDLE. Release with a non-memory op -> pass-through with no stall.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: executes byte-serial loads/stores over the shared
// byte-wide RAM port and holds the pipeline until the access completes.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic        mem_gnt_i,
   input  logic [7:0]  mem_din_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stall_req_o,
   output logic [31:0] mem_a_o,
   output logic [7:0]  mem_dout_o,
   output logic        mem_wr_o
);

   // state | meaning
   // IDLE  | pass-through, or launch of a memory op (counters cleared)
   // XFER  | issuing bytes / capturing load data, pipeline stalled
   // FIN   | result presented to MEM/WB, pipeline advances at this edge

   localparam logic [7:0] EX_LB  = 8'h20;
   localparam logic [7:0] EX_LH  = 8'h21;
   localparam logic [7:0] EX_LW  = 8'h22;
   localparam logic [7:0] EX_LBU = 8'h24;
   localparam logic [7:0] EX_LHU = 8'h25;
   localparam logic [7:0] EX_SB  = 8'h28;
   localparam logic [7:0] EX_SH  = 8'h29;
   localparam logic [7:0] EX_SW  = 8'h2A;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  iss_q, iss_d;
   logic        pend_q, pend_d;
   logic [31:0] buf_q, buf_d;

   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic [2:0]  size_n;
   logic        issue;
   logic [1:0]  cap_idx;
   logic [31:0] ext_data;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size_n   = 3'd0;
      case (aluop_i)
         EX_LB, EX_LBU: begin is_load  = 1'b1; size_n = 3'd1; end
         EX_LH, EX_LHU: begin is_load  = 1'b1; size_n = 3'd2; end
         EX_LW:         begin is_load  = 1'b1; size_n = 3'd4; end
         EX_SB:         begin is_store = 1'b1; size_n = 3'd1; end
         EX_SH:         begin is_store = 1'b1; size_n = 3'd2; end
         EX_SW:         begin is_store = 1'b1; size_n = 3'd4; end
         default:       ;
      endcase
   end

   assign is_mem  = is_load | is_store;
   assign issue   = (state_q == XFER) && (iss_q < size_n) && mem_gnt_i;
   // pending byte was issued with the previous count value; iss_q=4 wraps to lane 3
   assign cap_idx = iss_q[1:0] - 2'd1;

   always_comb begin
      case (aluop_i)
         EX_LB:   ext_data = {{24{buf_q[7]}}, buf_q[7:0]};
         EX_LBU:  ext_data = {24'h0, buf_q[7:0]};
         EX_LH:   ext_data = {{16{buf_q[15]}}, buf_q[15:0]};
         EX_LHU:  ext_data = {16'h0, buf_q[15:0]};
         EX_LW:   ext_data = buf_q;
         default: ext_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         iss_q   <= 3'd0;
         pend_q  <= 1'b0;
         buf_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         pend_q  <= pend_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      iss_d       = iss_q;
      pend_d      = pend_q;
      buf_d       = buf_q;
      wd_o        = wd_i;
      wreg_o      = 1'b0;
      wdata_o     = 32'h0;
      stall_req_o = 1'b0;
      mem_a_o     = 32'h0;
      mem_dout_o  = 8'h0;
      mem_wr_o    = 1'b0;

      case (state_q)
         IDLE: begin
            if (is_mem) begin
               stall_req_o = 1'b1;
               iss_d       = 3'd0;
               pend_d      = 1'b0;
               buf_d       = 32'h0;
               state_d     = XFER;
            end else begin
               wreg_o  = wreg_i;
               wdata_o = wdata_i;
            end
         end
         XFER: begin
            stall_req_o = 1'b1;
            if (pend_q)
               buf_d[{cap_idx, 3'b000} +: 8] = mem_din_i;
            if (issue) begin
               mem_a_o  = mem_addr_i + {29'd0, iss_q};
               mem_wr_o = is_store;
               if (is_store)
                  mem_dout_o = wdata_i[{iss_q[1:0], 3'b000} +: 8];
               iss_d  = iss_q + 3'd1;
               pend_d = is_load;
            end else begin
               pend_d = 1'b0;
            end
            if (is_store && issue && (iss_q == size_n - 3'd1))
               state_d = FIN;
            if (is_load && pend_q && (iss_q == size_n))
               state_d = FIN;
         end
         FIN: begin
            wreg_o  = wreg_i;
            wdata_o = ext_data;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         wd_o        = 5'd0;
         wreg_o      = 1'b0;
         wdata_o     = 32'h0;
         stall_req_o = 1'b0;
         mem_a_o     = 32'h0;
         mem_dout_o  = 8'h0;
         mem_wr_o    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a driver pushes expected writes/results
// from a byte-array memory model, a negedge monitor compares what the DUT presents.
`timescale 1ns/1ps
module tb_mem_access;

   localparam logic [7:0] EX_NOP = 8'h00;
   localparam logic [7:0] EX_ADD = 8'h01;
   localparam logic [7:0] EX_SUB = 8'h02;
   localparam logic [7:0] EX_OR  = 8'h05;
   localparam logic [7:0] EX_LB  = 8'h20;
   localparam logic [7:0] EX_LH  = 8'h21;
   localparam logic [7:0] EX_LW  = 8'h22;
   localparam logic [7:0] EX_LBU = 8'h24;
   localparam logic [7:0] EX_LHU = 8'h25;
   localparam logic [7:0] EX_SB  = 8'h28;
   localparam logic [7:0] EX_SH  = 8'h29;
   localparam logic [7:0] EX_SW  = 8'h2A;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [7:0]  aluop_i;
   logic [31:0] mem_addr_i;
   logic        mem_gnt_i;
   logic [7:0]  mem_din_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stall_req_o;
   logic [31:0] mem_a_o;
   logic [7:0]  mem_dout_o;
   logic        mem_wr_o;

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
      .mem_addr_i(mem_addr_i), .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
      .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o)
   );

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   int   n_vec = 0;
   int   n_err = 0;
   bit   active = 1'b0;
   res_t res_q[$];
   wr_t  wr_q[$];
   logic [7:0] ram [bit [31:0]];
   logic [7:0] mdl [bit [31:0]];
   logic [7:0] din_nxt = 8'h0;

   function automatic logic [7:0] def_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] rd_ram(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return def_byte(a);
   endfunction

   function automatic logic [7:0] rd_mdl(input logic [31:0] a);
      if (mdl.exists(a)) return mdl[a];
      return def_byte(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      ram[a] = d;
      mdl[a] = d;
   endtask

   // monitor: serves the RAM port and checks everything the DUT presents
   always @(negedge clk) begin
      wr_t  w;
      res_t r;
      if (!rst) begin
         if (mem_wr_o) begin
            if (wr_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_a_o, mem_dout_o);
            end else begin
               w = wr_q.pop_front();
               chk("wr_addr", mem_a_o, w.a);
               chk("wr_data", {24'h0, mem_dout_o}, {24'h0, w.d});
            end
            ram[mem_a_o] = mem_dout_o;
         end
         if (stall_req_o && !mem_gnt_i) begin
            chk("nogrant_addr", mem_a_o, 32'h0);
            chk("nogrant_wr", {31'h0, mem_wr_o}, 32'h0);
         end
         if (active && !stall_req_o) begin
            if (res_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got wdata %h, expected none", wdata_o);
            end else begin
               r = res_q.pop_front();
               chk("wd_o", {27'h0, wd_o}, {27'h0, r.wd});
               chk("wreg_o", {31'h0, wreg_o}, {31'h0, r.wreg});
               chk("wdata_o", wdata_o, r.wdata);
            end
         end
      end
      din_nxt = rd_ram(mem_a_o);
   end

   always @(posedge clk) begin
      #1 mem_din_i = din_nxt;
   end

   task automatic op_info(input logic [7:0] op, output int n, output bit ld, output bit st);
      n = 0; ld = 1'b0; st = 1'b0;
      case (op)
         EX_LB, EX_LBU: begin n = 1; ld = 1'b1; end
         EX_LH, EX_LHU: begin n = 2; ld = 1'b1; end
         EX_LW:         begin n = 4; ld = 1'b1; end
         EX_SB:         begin n = 1; st = 1'b1; end
         EX_SH:         begin n = 2; st = 1'b1; end
         EX_SW:         begin n = 4; st = 1'b1; end
         default:       ;
      endcase
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   endtask

   // cycle 0 is the one where inputs are applied; waits for the unstalled cycle
   task automatic wait_done(input int exp_cyc, input logic [31:0] mask, input string nm);
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         if (!stall_req_o) break;
         if (c >= 80) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got >%0d cycles, expected %0d", nm, c + 1, exp_cyc);
            finish_run();
         end
         @(posedge clk);
         #1;
         c++;
         mem_gnt_i = (c < 32) ? mask[c] : 1'b1;
      end
      chk({nm, "_cycles"}, c + 1, exp_cyc);
   endtask

   task automatic do_op(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] mask);
      int   n, got, last, exp_cyc;
      bit   ld, st, g;
      logic [31:0] v;
      res_t r;
      wr_t  w;
      op_info(op, n, ld, st);
      r.wd   = wd;
      r.wreg = wreg;
      if (ld) begin
         v = 32'h0;
         for (int k = 0; k < n; k++) v[8*k +: 8] = rd_mdl(addr + 32'(k));
         case (op)
            EX_LB:   r.wdata = {{24{v[7]}}, v[7:0]};
            EX_LBU:  r.wdata = {24'h0, v[7:0]};
            EX_LH:   r.wdata = {{16{v[15]}}, v[15:0]};
            EX_LHU:  r.wdata = {16'h0, v[15:0]};
            default: r.wdata = v;
         endcase
      end else if (st) begin
         r.wdata = 32'h0;
         for (int k = 0; k < n; k++) begin
            w.a = addr + 32'(k);
            w.d = wdat[8*k +: 8];
            wr_q.push_back(w);
            mdl[w.a] = w.d;
         end
      end else begin
         r.wdata = wdat;
      end
      res_q.push_back(r);

      // one IDLE cycle, n granted issue cycles, one capture cycle for loads, FIN
      if (!(ld || st)) begin
         exp_cyc = 1;
      end else begin
         got = 0; last = 0;
         for (int c = 1; got < n; c++) begin
            g = (c < 32) ? mask[c] : 1'b1;
            if (g) begin
               got++;
               if (got == n) last = c;
            end
         end
         exp_cyc = last + (ld ? 3 : 2);
      end

      @(posedge clk);
      #1;
      aluop_i    = op;
      mem_addr_i = addr;
      wdata_i    = wdat;
      wd_i       = wd;
      wreg_i     = wreg;
      mem_gnt_i  = mask[0];
      active     = 1'b1;
      wait_done(exp_cyc, mask, nm);
   endtask

   task automatic reset_mid_sw();
      wr_t  w;
      res_t r;
      logic [31:0] sd;
      sd = 32'h11223344;
      for (int k = 0; k < 2; k++) begin
         w.a = 32'h200 + 32'(k);
         w.d = sd[8*k +: 8];
         wr_q.push_back(w);
         mdl[w.a] = w.d;
      end
      @(posedge clk);
      #1;
      aluop_i = EX_SW; mem_addr_i = 32'h200; wdata_i = sd;
      wd_i = 5'd3; wreg_i = 1'b1; mem_gnt_i = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_wd_o", {27'h0, wd_o}, 32'h0);
      chk("rst_wreg_o", {31'h0, wreg_o}, 32'h0);
      chk("rst_wdata_o", wdata_o, 32'h0);
      chk("rst_stall", {31'h0, stall_req_o}, 32'h0);
      chk("rst_mem_a", mem_a_o, 32'h0);
      chk("rst_mem_dout", {24'h0, mem_dout_o}, 32'h0);
      chk("rst_mem_wr", {31'h0, mem_wr_o}, 32'h0);
      r.wd = 5'd9; r.wreg = 1'b1; r.wdata = 32'hCAFE_0001;
      res_q.push_back(r);
      @(posedge clk);
      #1;
      aluop_i = EX_ADD; mem_addr_i = 32'h0; wdata_i = 32'hCAFE_0001;
      wd_i = 5'd9; wreg_i = 1'b1; mem_gnt_i = 1'b1;
      #1 rst = 1'b0;
      wait_done(1, 32'hFFFF_FFFF, "post_rst_pass");
   endtask

   initial begin
      logic [7:0]  ops [12];
      logic [7:0]  op;
      logic [31:0] addr, mask;
      ops = '{EX_ADD, EX_SUB, EX_OR, EX_NOP, EX_LB, EX_LH, EX_LW, EX_LBU,
              EX_LHU, EX_SB, EX_SH, EX_SW};
      rst = 1'b1;
      aluop_i = EX_ADD; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234;
      mem_addr_i = 32'h0; mem_gnt_i = 1'b1; mem_din_i = 8'h0;
      repeat (2) @(negedge clk);
      chk("reset_wd_o", {27'h0, wd_o}, 32'h0);
      chk("reset_wreg_o", {31'h0, wreg_o}, 32'h0);
      chk("reset_wdata_o", wdata_o, 32'h0);
      chk("reset_stall", {31'h0, stall_req_o}, 32'h0);
      chk("reset_mem_wr", {31'h0, mem_wr_o}, 32'h0);
      #2 rst = 1'b0;

      preload(32'h20, 8'h80);
      preload(32'h40, 8'h34);
      preload(32'h41, 8'h12);
      preload(32'hFFFF_FFFE, 8'h11);
      preload(32'hFFFF_FFFF, 8'h22);
      preload(32'h0000_0000, 8'h33);
      preload(32'h0000_0001, 8'h44);

      do_op("pass_add", EX_ADD, 32'h0, 32'h1234, 5'd5, 1'b1, 32'hFFFF_FFFF);
      do_op("lw_wrap", EX_LW, 32'hFFFF_FFFE, 32'h0, 5'd6, 1'b1, 32'hFFFF_FFFF);
      chk("lw_wrap_const", wdata_o, 32'h4433_2211);
      do_op("sw", EX_SW, 32'h100, 32'hA1B2_C3D4, 5'd0, 1'b0, 32'hFFFF_FFFF);
      do_op("lb", EX_LB, 32'h20, 32'h0, 5'd7, 1'b1, 32'hFFFF_FFFF);
      chk("lb_const", wdata_o, 32'hFFFF_FF80);
      do_op("lbu", EX_LBU, 32'h20, 32'h0, 5'd8, 1'b1, 32'hFFFF_FFFF);
      chk("lbu_const", wdata_o, 32'h0000_0080);
      do_op("lh_gap", EX_LH, 32'h40, 32'h0, 5'd10, 1'b1, 32'hFFFF_FFF3);
      chk("lh_gap_const", wdata_o, 32'h0000_1234);
      do_op("sb", EX_SB, 32'h101, 32'h0000_0077, 5'd0, 1'b0, 32'hFFFF_FFFF);
      do_op("sh_wrap", EX_SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 5'd0, 1'b0, 32'hFFFF_FFFF);
      do_op("lw_back", EX_LW, 32'h100, 32'h0, 5'd11, 1'b1, 32'hFFFF_FFFF);
      do_op("lhu_wrap", EX_LHU, 32'hFFFF_FFFF, 32'h0, 5'd12, 1'b1, 32'hFFFF_FFFF);
      chk("lhu_wrap_const", wdata_o, 32'h0000_BEEF);

      reset_mid_sw();
      do_op("lw_after_rst", EX_LW, 32'h200, 32'h0, 5'd13, 1'b1, 32'hFFFF_FFFF);

      for (int i = 0; i < 300; i++) begin
         op = ops[$urandom_range(0, 11)];
         if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         else                           addr = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) mask = 32'hFFFF_FFFF;
         else                           mask = $urandom | $urandom;
         do_op("rand", op, addr, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), mask);
      end

      @(posedge clk);
      #1 active = 1'b0;
      chk("res_q_empty", res_q.size(), 32'h0);
      chk("wr_q_empty", wr_q.size(), 32'h0);
      finish_run();
   end

endmodule
